// File: rtl/prog_sync_gen.sv
// rtl/prog_sync_gen.sv - programmable video sync generator with shadowed timing sets
module prog_sync_gen #(
    parameter int CW        = 11,
    parameter int DEF_H_ACT = 800,
    parameter int DEF_H_SS  = 856,
    parameter int DEF_H_SE  = 976,
    parameter int DEF_H_TOT = 1040,
    parameter int DEF_V_ACT = 600,
    parameter int DEF_V_SS  = 637,
    parameter int DEF_V_SE  = 643,
    parameter int DEF_V_TOT = 666,
    parameter bit DEF_HPOL  = 1'b1,
    parameter bit DEF_VPOL  = 1'b1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_h_act,
    input  logic [CW-1:0] cfg_h_ss,
    input  logic [CW-1:0] cfg_h_se,
    input  logic [CW-1:0] cfg_h_tot,
    input  logic [CW-1:0] cfg_v_act,
    input  logic [CW-1:0] cfg_v_ss,
    input  logic [CW-1:0] cfg_v_se,
    input  logic [CW-1:0] cfg_v_tot,
    input  logic          cfg_hpol,
    input  logic          cfg_vpol,
    output logic [CW-1:0] xpos,
    output logic [CW-1:0] ypos,
    output logic          hsync,
    output logic          vsync,
    output logic          disp_active,
    output logic          frame_start,
    output logic          cfg_err
);

    typedef struct packed {
        logic [CW-1:0] h_act;
        logic [CW-1:0] h_ss;
        logic [CW-1:0] h_se;
        logic [CW-1:0] h_tot;
        logic [CW-1:0] v_act;
        logic [CW-1:0] v_ss;
        logic [CW-1:0] v_se;
        logic [CW-1:0] v_tot;
        logic          hpol;
        logic          vpol;
    } timing_t;

    localparam timing_t DEF_SET = '{
        h_act: CW'(DEF_H_ACT), h_ss: CW'(DEF_H_SS), h_se: CW'(DEF_H_SE), h_tot: CW'(DEF_H_TOT),
        v_act: CW'(DEF_V_ACT), v_ss: CW'(DEF_V_SS), v_se: CW'(DEF_V_SE), v_tot: CW'(DEF_V_TOT),
        hpol: DEF_HPOL, vpol: DEF_VPOL
    };

    timing_t       act_q, sh_q, cfg_in;
    logic          pending_q;
    logic [CW-1:0] hc_q, vc_q, hc_d, vc_d;
    logic          cfg_legal, xfer, hc_last, vc_last, boundary;
    logic [CW-1:0] xpos_q, ypos_q;
    logic          hsync_q, vsync_q, disp_active_q, frame_start_q, cfg_err_q;

    // Offered set, its legality, and counter next-state under the ACTIVE timing
    always_comb begin
        cfg_in = '{
            h_act: cfg_h_act, h_ss: cfg_h_ss, h_se: cfg_h_se, h_tot: cfg_h_tot,
            v_act: cfg_v_act, v_ss: cfg_v_ss, v_se: cfg_v_se, v_tot: cfg_v_tot,
            hpol: cfg_hpol, vpol: cfg_vpol
        };
        cfg_legal = (cfg_h_act != '0) && (cfg_h_act <= cfg_h_ss) && (cfg_h_ss < cfg_h_se) &&
                    (cfg_h_se <= cfg_h_tot) && (cfg_h_tot >= CW'(2)) &&
                    (cfg_v_act != '0) && (cfg_v_act <= cfg_v_ss) && (cfg_v_ss < cfg_v_se) &&
                    (cfg_v_se <= cfg_v_tot) && (cfg_v_tot >= CW'(2));
        xfer     = cfg_valid && !pending_q;
        hc_last  = (hc_q == act_q.h_tot - CW'(1));
        vc_last  = (vc_q == act_q.v_tot - CW'(1));
        boundary = hc_last && vc_last;
        hc_d     = hc_q + CW'(1);
        vc_d     = vc_q;
        if (hc_last) begin
            hc_d = '0;
            vc_d = vc_last ? '0 : vc_q + CW'(1);
        end
    end

    // Counters, timing sets and registered strobes; ACTIVE only changes at the frame boundary
    always_ff @(posedge clock) begin
        if (!reset) begin
            hc_q          <= '0;
            vc_q          <= '0;
            act_q         <= DEF_SET;
            sh_q          <= DEF_SET;
            pending_q     <= 1'b0;
            xpos_q        <= '0;
            ypos_q        <= '0;
            hsync_q       <= ~DEF_HPOL;
            vsync_q       <= ~DEF_VPOL;
            disp_active_q <= 1'b0;
            frame_start_q <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            xpos_q        <= hc_q;
            ypos_q        <= vc_q;
            hsync_q       <= ((hc_q >= act_q.h_ss) && (hc_q < act_q.h_se)) ? act_q.hpol : ~act_q.hpol;
            vsync_q       <= ((vc_q >= act_q.v_ss) && (vc_q < act_q.v_se)) ? act_q.vpol : ~act_q.vpol;
            disp_active_q <= (hc_q < act_q.h_act) && (vc_q < act_q.v_act);
            frame_start_q <= (hc_q == '0) && (vc_q == '0);
            cfg_err_q     <= xfer && !cfg_legal;
            // A transfer cannot coincide with a switch because xfer needs pending clear
            if (boundary && pending_q) begin
                act_q     <= sh_q;
                pending_q <= 1'b0;
            end else if (xfer && cfg_legal) begin
                sh_q      <= cfg_in;
                pending_q <= 1'b1;
            end
        end
    end

    assign cfg_ready   = ~pending_q;
    assign xpos        = xpos_q;
    assign ypos        = ypos_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign disp_active = disp_active_q;
    assign frame_start = frame_start_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_prog_sync_gen.sv
// tb/tb_prog_sync_gen.sv - self-checking bench for prog_sync_gen against a timing-set model
module tb_prog_sync_gen;

    localparam int CW = 11;

    typedef struct {
        int ha, hs, he, ht, va, vs, ve, vt;
        bit hp, vp;
    } tset_t;

    localparam tset_t DEF = '{20, 23, 27, 30, 10, 12, 14, 16, 1'b1, 1'b1};

    logic          clock = 1'b0;
    logic          reset;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [CW-1:0] cfg_h_act, cfg_h_ss, cfg_h_se, cfg_h_tot;
    logic [CW-1:0] cfg_v_act, cfg_v_ss, cfg_v_se, cfg_v_tot;
    logic          cfg_hpol, cfg_vpol;
    logic [CW-1:0] xpos, ypos;
    logic          hsync, vsync, disp_active, frame_start, cfg_err;

    tset_t cfg;

    assign cfg_h_act = CW'(cfg.ha);
    assign cfg_h_ss  = CW'(cfg.hs);
    assign cfg_h_se  = CW'(cfg.he);
    assign cfg_h_tot = CW'(cfg.ht);
    assign cfg_v_act = CW'(cfg.va);
    assign cfg_v_ss  = CW'(cfg.vs);
    assign cfg_v_se  = CW'(cfg.ve);
    assign cfg_v_tot = CW'(cfg.vt);
    assign cfg_hpol  = cfg.hp;
    assign cfg_vpol  = cfg.vp;

    prog_sync_gen #(
        .CW(CW),
        .DEF_H_ACT(20), .DEF_H_SS(23), .DEF_H_SE(27), .DEF_H_TOT(30),
        .DEF_V_ACT(10), .DEF_V_SS(12), .DEF_V_SE(14), .DEF_V_TOT(16),
        .DEF_HPOL(1'b1), .DEF_VPOL(1'b1)
    ) dut (
        .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_h_act(cfg_h_act), .cfg_h_ss(cfg_h_ss), .cfg_h_se(cfg_h_se), .cfg_h_tot(cfg_h_tot),
        .cfg_v_act(cfg_v_act), .cfg_v_ss(cfg_v_ss), .cfg_v_se(cfg_v_se), .cfg_v_tot(cfg_v_tot),
        .cfg_hpol(cfg_hpol), .cfg_vpol(cfg_vpol),
        .xpos(xpos), .ypos(ypos), .hsync(hsync), .vsync(vsync),
        .disp_active(disp_active), .frame_start(frame_start), .cfg_err(cfg_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // model state: position within the frame, timing in force, queued timing
    tset_t act, sh;
    int    mx, my;
    bit    mpend;
    int    ex, ey;
    bit    ehs, evs, eda, efs, eerr;

    int fs_n, da_n, hs_n, vs_n;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input tset_t s);
        return s.ha > 0 && s.ha <= s.hs && s.hs < s.he && s.he <= s.ht && s.ht >= 2 &&
               s.va > 0 && s.va <= s.vs && s.vs < s.ve && s.ve <= s.vt && s.vt >= 2;
    endfunction

    task automatic model_edge(input bit r, input bit v, input tset_t c);
        bit last_px;
        if (!r) begin
            mx = 0; my = 0; act = DEF; sh = DEF; mpend = 0;
            ex = 0; ey = 0; ehs = !DEF.hp; evs = !DEF.vp; eda = 0; efs = 0; eerr = 0;
        end else begin
            ex   = mx;
            ey   = my;
            ehs  = (mx >= act.hs && mx < act.he) ? act.hp : !act.hp;
            evs  = (my >= act.vs && my < act.ve) ? act.vp : !act.vp;
            eda  = (mx < act.ha) && (my < act.va);
            efs  = (mx == 0) && (my == 0);
            eerr = v && !mpend && !legal(c);
            last_px = (mx == act.ht - 1) && (my == act.vt - 1);
            mx++;
            if (mx == act.ht) begin
                mx = 0;
                my++;
                if (my == act.vt) my = 0;
            end
            if (last_px && mpend) begin
                act = sh;
                mpend = 0;
            end else if (v && !mpend && legal(c)) begin
                sh = c;
                mpend = 1;
            end
        end
    endtask

    task automatic tick();
        bit r, v;
        tset_t c;
        r = reset; v = cfg_valid; c = cfg;
        @(posedge clock);
        model_edge(r, v, c);
        @(negedge clock);
        check("xpos", xpos, ex);
        check("ypos", ypos, ey);
        check("hsync", hsync, ehs);
        check("vsync", vsync, evs);
        check("disp_active", disp_active, eda);
        check("frame_start", frame_start, efs);
        check("cfg_err", cfg_err, eerr);
        check("cfg_ready", cfg_ready, !mpend);
        if (frame_start) fs_n++;
        if (disp_active) da_n++;
        if (hsync) hs_n++;
        if (vsync) vs_n++;
    endtask

    task automatic clear_counts();
        fs_n = 0; da_n = 0; hs_n = 0; vs_n = 0;
    endtask

    // ticks until a frame_start is seen; returns how many ticks that took
    task automatic wait_fs(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame_start && n < 2000);
        check("fs_timeout", frame_start, 1);
    endtask

    function automatic tset_t rand_set();
        tset_t s;
        s.ht = $urandom_range(2, 24);
        s.ha = $urandom_range(1, s.ht - 1);
        s.hs = $urandom_range(s.ha, s.ht - 1);
        s.he = $urandom_range(s.hs + 1, s.ht);
        s.vt = $urandom_range(2, 24);
        s.va = $urandom_range(1, s.vt - 1);
        s.vs = $urandom_range(s.va, s.vt - 1);
        s.ve = $urandom_range(s.vs + 1, s.vt);
        s.hp = 1'($urandom_range(0, 1));
        s.vp = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 3))
                0: s.ha = $urandom_range(0, 31);
                1: s.he = $urandom_range(0, 31);
                2: s.vt = $urandom_range(0, 31);
                default: s.vs = $urandom_range(0, 31);
            endcase
        end
        return s;
    endfunction

    initial begin
        int p;
        tset_t sw_set, a_set, b_set, bad_set, min_set;
        sw_set  = '{16, 18, 21, 24, 12, 13, 15, 18, 1'b0, 1'b0};
        a_set   = '{20, 22, 25, 28, 8, 9, 10, 12, 1'b1, 1'b0};
        b_set   = '{12, 13, 14, 16, 6, 7, 8, 9, 1'b1, 1'b1};
        bad_set = '{16, 10, 14, 16, 6, 7, 8, 9, 1'b1, 1'b1};
        min_set = '{1, 1, 2, 2, 1, 1, 2, 2, 1'b1, 1'b1};

        reset = 1'b0;
        cfg_valid = 1'b0;
        cfg = DEF;
        clear_counts();
        tick();
        tick();
        check("rst_ready", cfg_ready, 1);
        check("rst_hsync", hsync, 0);
        check("rst_vsync", vsync, 0);
        check("rst_fs", frame_start, 0);

        // free run with default timing for two frames
        reset = 1'b1;
        clear_counts();
        tick();
        check("first_fs", frame_start, 1);
        check("first_da", disp_active, 1);
        repeat (959) tick();
        check("def_fs_count", fs_n, 2);
        check("def_active_px", da_n, 2 * 20 * 10);
        check("def_hsync_high", hs_n, 2 * 16 * 4);
        check("def_vsync_high", vs_n, 2 * 30 * 2);

        // mode switch offered mid-frame
        wait_fs(p);
        repeat (100) tick();
        cfg = sw_set;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        check("sw_pending_ready", cfg_ready, 0);
        wait_fs(p);
        check("sw_old_frame_len", p + 101, 480);
        clear_counts();
        wait_fs(p);
        check("sw_frame_len", p, 24 * 18);
        check("sw_active_px", da_n, 16 * 12);
        check("sw_hsync_high", hs_n, 24 * 18 - 3 * 18);
        check("sw_vsync_high", vs_n, 24 * 18 - 2 * 24);
        check("sw_fs_count", fs_n, 1);

        // back-pressure: A pending, B held valid until accepted
        repeat (5) tick();
        cfg = a_set;
        cfg_valid = 1'b1;
        tick();
        check("bp_a_pending", cfg_ready, 0);
        cfg = b_set;
        wait_fs(p);
        check("bp_b_accepted", cfg_ready, 0);
        cfg_valid = 1'b0;
        wait_fs(p);
        check("bp_a_frame_len", p, 28 * 12);
        wait_fs(p);
        check("bp_b_frame_len", p, 16 * 9);

        // illegal set is refused without disturbing timing
        repeat (7) tick();
        cfg = bad_set;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        check("bad_err", cfg_err, 1);
        check("bad_ready", cfg_ready, 1);
        tick();
        check("bad_err_once", cfg_err, 0);
        wait_fs(p);
        wait_fs(p);
        check("bad_frame_len", p, 16 * 9);

        // reset mid-frame discards the pending set
        repeat (3) tick();
        cfg = sw_set;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        check("rst2_pending", cfg_ready, 0);
        repeat (4) tick();
        reset = 1'b0;
        tick();
        check("rst2_ready", cfg_ready, 1);
        check("rst2_xpos", xpos, 0);
        check("rst2_da", disp_active, 0);
        reset = 1'b1;
        wait_fs(p);
        check("rst2_first_fs", p, 1);
        wait_fs(p);
        check("rst2_def_len", p, 480);

        // minimum totals
        cfg = min_set;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        wait_fs(p);
        for (int i = 0; i < 3; i++) begin
            wait_fs(p);
            check("min_frame_len", p, 4);
        end

        // random offers and occasional resets
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 399) != 0);
            cfg_valid = ($urandom_range(0, 19) == 0);
            cfg = rand_set();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
